mtm_alu_deserializer: RTL and testbench
=======================================

Name: mtm_alu_deserializer

Overview:
- Serial input front end of the mtm_alu datapath; sits directly downstream of the sin line driven by the test bench.
- Parses 11-bit serial frames into 8-byte data plus 1 CTL packets and checks the CRC4 and the opcode.
- Presents operands B, A and the operation, or an error-flag word, to the ALU core as a one-cycle pulse.

Parameters:
- DATA_FRAMES, 8, number of data frames per packet (B bytes then A bytes, MSB byte first).
- TIMEOUT_CYCLES, 1000, idle cycles between frames before a partial packet is dropped (used only with MTM_DESER_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sin  input  1  serial input; idles at 1; one bit per clk.
- out_valid  output  1  one-cycle pulse: out_a/out_b/out_op valid.
- out_a  output  32  operand A.
- out_b  output  32  operand B.
- out_op  output  3  opcode (AND 000, OR 001, ADD 100, SUB 101).
- err_valid  output  1  one-cycle pulse: err_flags valid.
- err_flags  output  3  {data, crc, op}.
- busy  output  1  high while a packet is partially received.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Frame format, MSB first: start 0, type bit (0 = data, 1 = CTL), 8 payload bits, stop 1. Total 11 bits.
- Frame FSM states:
  - IDLE: sin=0 moves to SHIFT.
  - SHIFT: samples 10 bits with a 4-bit counter.
  - STOP_CHK: evaluates the stop bit in the cycle after it is sampled.
  - Return to IDLE immediately, so back-to-back frames need no idle bit.
- Stop bit = 0 (framing error):
  - Discard the current packet and raise data error.
  - Go to RESYNC; wait for sin=1, then IDLE.
- Packet layer:
  - Data frame: shift the payload into a 64-bit {B,A} register and increment data_cnt (0..DATA_FRAMES).
  - A data frame arriving while data_cnt==DATA_FRAMES sets a sticky overflow flag; its payload is discarded.
- CTL frame payload: bit7 = 0, op = bits 6:4, crc = bits 3:0.
- CRC4 check:
  - Polynomial x^4+x+1, init 0.
  - Computed serially over {B,A,1'b1,op} (68 bits); may be accumulated per frame.
- CTL frame decision, in priority order:
  - data_cnt!=DATA_FRAMES or overflow: err_flags=100.
  - CRC mismatch: 010.
  - op not in {000,001,100,101}: 001.
  - Otherwise out_valid.
- Exactly one of out_valid/err_valid pulses per CTL frame, one cycle after the CTL stop bit is sampled.
- Outputs are registered. out_a/out_b/out_op hold their values until the next out_valid; err_flags holds until the next err_valid.
- After any CTL frame: data_cnt, overflow and CRC are cleared.
- No backpressure: the consumer must accept each pulse.
- busy:
  - High from the first data frame's start bit until the end-of-packet pulse.
  - Also high during RESYNC.
- Reset:
  - All outputs 0; FSM to IDLE; data_cnt, overflow and CRC cleared.
  - Reset mid-frame or mid-packet drops the partial packet silently, with no err_valid.
- A reset asserted in the same cycle as a pending pulse suppresses the pulse.

Optional Feature:
- Macro: MTM_DESER_TIMEOUT_EN.
- Defined:
  - An idle counter runs while busy=1 and the FSM is in IDLE.
  - On reaching TIMEOUT_CYCLES: drop the partial packet and pulse err_valid with err_flags=100.
  - The counter clears on every start bit.
- Undefined: no counter; a partial packet waits indefinitely.

Test Plan:
- Valid ADD, B=0x00000002, A=0x00000001, correct CRC from the bench CRC4 model -> single out_valid; out_b=0x00000002, out_a=0x00000001, out_op=100; err_valid stays 0.
- Same packet with the CRC field XOR 4'b0001 -> err_valid, err_flags=010; out_valid stays 0.
- Data-count errors, each -> err_flags=100:
  - 7 data frames then a valid CTL.
  - 9 data frames then a valid CTL.
  - A following valid packet -> normal out_valid.
- op=3'b010 with a CRC computed over that op -> err_flags=001.
- Framing and reset:
  - Stop bit forced to 0 in data frame 3 -> err_valid with err_flags=100 after the stop-bit check. The FSM resyncs, and the next valid SUB packet -> out_valid, out_op=101.
  - reset asserted for 1 cycle after 4 data frames, then a full valid AND packet -> exactly one out_valid, out_op=000, no err_valid.
- With MTM_DESER_TIMEOUT_EN: 3 data frames, then sin=1 for TIMEOUT_CYCLES -> err_valid, err_flags=100, busy=0.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mtm_alu_deserializer                                            |
// | Function : Serial front end of the mtm_alu datapath. Parses 11-bit frames  |
// |            (start, type, 8 payload, stop) into DATA_FRAMES data bytes plus |
// |            one CTL frame. It then checks the frame count, CRC4 (x^4+x+1)   |
// |            and opcode, and pulses either the operands or an error word.    |
// | Options  : MTM_DESER_TIMEOUT_EN - drop a stalled partial packet after      |
// |            TIMEOUT_CYCLES idle cycles and report a data error.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mtm_alu_deserializer #(
   parameter int DATA_FRAMES    = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sin,
   output logic        out_valid,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [2:0]  out_op,
   output logic        err_valid,
   output logic [2:0]  err_flags,
   output logic        busy
);

   localparam int               CNT_W    = $clog2(DATA_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAMES);
   localparam logic [3:0]       LAST_BIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      STOP_CHK = 2'd2,
      RESYNC   = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [3:0]       bit_cnt;
   logic [9:0]       frame_sr;      // {type, payload[7:0], stop} once complete
   logic [63:0]      data_sr;       // {B, A}, first byte ends up in the MSBs
   logic [CNT_W-1:0] data_cnt;
   logic             overflow;
   logic [3:0]       crc;
   logic             start_bit;
   logic             frame_end;
   logic             timeout_hit;
   logic             frame_is_ctl;
   logic             stop_ok;
   logic [7:0]       payload;
   logic [3:0]       ctl_tail;
   logic [3:0]       crc_data;
   logic [3:0]       crc_ctl;
   logic             op_legal;

   assign frame_is_ctl = frame_sr[9];
   assign payload      = frame_sr[8:1];
   assign stop_ok      = frame_sr[0];
   assign ctl_tail     = {1'b1, payload[6:4]};
   assign op_legal     = (payload[6:4] == 3'b000) || (payload[6:4] == 3'b001) ||
                         (payload[6:4] == 3'b100) || (payload[6:4] == 3'b101);
   assign busy         = (state != IDLE) || (data_cnt != '0) || overflow;

   // One serial step of the x^4+x+1 LFSR, message bit fed at the top.
   function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
      logic fb;
      fb = c[3] ^ b;
      return {c[2], c[1], c[0] ^ fb, fb};
   endfunction

   // CRC advanced over a data byte and over the CTL tail {1, op}.
   always_comb begin
      crc_data = crc;
      for (int i = 7; i >= 0; i--) crc_data = crc4_step(crc_data, payload[i]);
      crc_ctl = crc;
      for (int i = 3; i >= 0; i--) crc_ctl = crc4_step(crc_ctl, ctl_tail[i]);
   end

   // Frame FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Frame FSM next state; STOP_CHK can accept an immediate start bit.
   always_comb begin
      next_state = state;
      start_bit  = 1'b0;
      frame_end  = 1'b0;
      case (state)
         IDLE: begin
            if (!sin) begin
               next_state = SHIFT;
               start_bit  = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_cnt == LAST_BIT) next_state = STOP_CHK;
         end
         STOP_CHK: begin
            frame_end = 1'b1;
            if (!stop_ok) begin
               next_state = RESYNC;
            end else if (!sin) begin
               next_state = SHIFT;
               start_bit  = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         RESYNC: begin
            if (sin) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Bit counter and frame shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt  <= 4'd0;
         frame_sr <= 10'd0;
      end else if (start_bit) begin
         bit_cnt  <= 4'd0;
      end else if (state == SHIFT) begin
         frame_sr <= {frame_sr[8:0], sin};
         bit_cnt  <= bit_cnt + 4'd1;
      end
   end

   // Packet assembly, CTL decision and registered result pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_sr   <= 64'd0;
         data_cnt  <= '0;
         overflow  <= 1'b0;
         crc       <= 4'd0;
         out_valid <= 1'b0;
         out_a     <= 32'd0;
         out_b     <= 32'd0;
         out_op    <= 3'd0;
         err_valid <= 1'b0;
         err_flags <= 3'd0;
      end else begin
         out_valid <= 1'b0;
         err_valid <= 1'b0;
         if (frame_end && !stop_ok) begin
            // Framing error: drop whatever was collected.
            err_valid <= 1'b1;
            err_flags <= 3'b100;
            data_cnt  <= '0;
            overflow  <= 1'b0;
            crc       <= 4'd0;
         end else if (frame_end && !frame_is_ctl) begin
            if (data_cnt == CNT_FULL) begin
               overflow <= 1'b1;
            end else begin
               data_sr  <= {data_sr[55:0], payload};
               data_cnt <= data_cnt + CNT_W'(1);
               crc      <= crc_data;
            end
         end else if (frame_end) begin
            if ((data_cnt != CNT_FULL) || overflow) begin
               err_valid <= 1'b1;
               err_flags <= 3'b100;
            end else if (crc_ctl != payload[3:0]) begin
               err_valid <= 1'b1;
               err_flags <= 3'b010;
            end else if (!op_legal) begin
               err_valid <= 1'b1;
               err_flags <= 3'b001;
            end else begin
               out_valid <= 1'b1;
               out_b     <= data_sr[63:32];
               out_a     <= data_sr[31:0];
               out_op    <= payload[6:4];
            end
            data_cnt <= '0;
            overflow <= 1'b0;
            crc      <= 4'd0;
         end else if (timeout_hit) begin
            err_valid <= 1'b1;
            err_flags <= 3'b100;
            data_cnt  <= '0;
            overflow  <= 1'b0;
            crc       <= 4'd0;
         end
      end
   end

`ifdef MTM_DESER_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0] idle_cnt;

   assign timeout_hit = busy && (state == IDLE) && !start_bit &&
                        (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

   // Idle gap counter while a partial packet waits for its next frame.
   always_ff @(posedge clk) begin
      if (reset || start_bit || !busy || (state != IDLE) || timeout_hit)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + IDLE_W'(1);
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mtm_alu_deserializer                                         |
// | Function : Randomized scoreboard bench for mtm_alu_deserializer. Expected  |
// |            results come from a packet-level reference model (polynomial    |
// |            division CRC, count/op rules).                                  |
// | Options  : MTM_DESER_TIMEOUT_EN - also exercises the idle timeout.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mtm_alu_deserializer;

   localparam int TIMEOUT_CYCLES = 1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        sin;
   logic        out_valid;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [2:0]  out_op;
   logic        err_valid;
   logic [2:0]  err_flags;
   logic        busy;

   mtm_alu_deserializer #(
      .DATA_FRAMES    (8),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sin       (sin),
      .out_valid (out_valid),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_op    (out_op),
      .err_valid (err_valid),
      .err_flags (err_flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [2:0]  flags;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   function automatic void check(input bit ok, input string name,
                                 input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Reference CRC: remainder of {B,A,1,op}*x^4 divided by x^4+x+1.
   function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a,
                                            input logic [2:0] op);
      logic [71:0] m;
      m = {b, a, 1'b1, op, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
      return m[3:0];
   endfunction

   function automatic bit op_is_legal(input logic [2:0] op);
      return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
   endfunction

   // Monitor: every pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (out_valid || err_valid) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_pulse", {62'd0, out_valid, err_valid}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_err) begin
               check(err_valid && !out_valid, "pulse_kind_err",
                     {62'd0, out_valid, err_valid}, 64'd1);
               check(err_flags == mon_e.flags, "err_flags", 64'(err_flags), 64'(mon_e.flags));
            end else begin
               check(out_valid && !err_valid, "pulse_kind_ok",
                     {62'd0, out_valid, err_valid}, 64'd2);
               check(out_a == mon_e.a, "out_a", 64'(out_a), 64'(mon_e.a));
               check(out_b == mon_e.b, "out_b", 64'(out_b), 64'(mon_e.b));
               check(out_op == mon_e.op, "out_op", 64'(out_op), 64'(mon_e.op));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sin = 1'b1;
      end
   endtask

   task automatic send_frame(input bit ctl, input logic [7:0] pay, input bit stop);
      logic [10:0] f;
      f = {1'b0, ctl, pay, stop};
      for (int i = 10; i >= 0; i--) begin
         @(negedge clk);
         sin = f[i];
      end
   endtask

   task automatic push_err(input logic [2:0] flags);
      exp_t e;
      e.is_err = 1'b1; e.flags = flags; e.a = '0; e.b = '0; e.op = '0;
      exp_q.push_back(e);
   endtask

   // Sends one packet and records what the model predicts for it.
   task automatic send_packet(input int ndata, input logic [31:0] b, input logic [31:0] a,
                              input logic [2:0] op, input logic [3:0] crc_xor,
                              input int bad_frame, input int gap_max);
      logic [7:0]  bytes [0:8];
      logic [63:0] ba;
      logic [3:0]  crc_f;
      exp_t        e;
      ba = {b, a};
      for (int i = 0; i < 8; i++) bytes[i] = ba[63 - 8*i -: 8];
      bytes[8] = 8'($urandom);
      for (int i = 0; i < ndata; i++) begin
         if (i == bad_frame) begin
            push_err(3'b100);
            send_frame(1'b0, bytes[i], 1'b0);
            idle(2);
            return;
         end
         send_frame(1'b0, bytes[i], 1'b1);
         idle(int'($urandom_range(0, gap_max)));
      end
      crc_f = crc_model(b, a, op) ^ crc_xor;
      if (ndata != 8)                       push_err(3'b100);
      else if (crc_f != crc_model(b, a, op)) push_err(3'b010);
      else if (!op_is_legal(op))            push_err(3'b001);
      else begin
         e.is_err = 1'b0; e.flags = '0; e.a = a; e.b = b; e.op = op;
         exp_q.push_back(e);
      end
      send_frame(1'b1, {1'b0, op, crc_f}, 1'b1);
      idle(int'($urandom_range(0, gap_max)));
   endtask

   logic [2:0] legal_ops [0:3];
   logic [2:0] bad_ops   [0:3];
   int         cat;

   initial begin
      legal_ops[0] = 3'b000; legal_ops[1] = 3'b001; legal_ops[2] = 3'b100; legal_ops[3] = 3'b101;
      bad_ops[0]   = 3'b010; bad_ops[1]   = 3'b011; bad_ops[2]   = 3'b110; bad_ops[3]   = 3'b111;
      reset = 1'b1;
      sin   = 1'b1;
      repeat (3) @(negedge clk);
      check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
      check(err_valid == 1'b0, "rst_err_valid", 64'(err_valid), 64'd0);
      check(out_a == 32'd0, "rst_out_a", 64'(out_a), 64'd0);
      check(out_b == 32'd0, "rst_out_b", 64'(out_b), 64'd0);
      check(out_op == 3'd0, "rst_out_op", 64'(out_op), 64'd0);
      check(err_flags == 3'd0, "rst_err_flags", 64'(err_flags), 64'd0);
      check(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      idle(2);

      // Directed cases.
      send_packet(8, 32'h2, 32'h1, 3'b100, 4'h0, -1, 0);
      send_packet(8, 32'h2, 32'h1, 3'b100, 4'h1, -1, 1);
      send_packet(7, 32'h2, 32'h1, 3'b100, 4'h0, -1, 1);
      send_packet(9, 32'h2, 32'h1, 3'b100, 4'h0, -1, 1);
      send_packet(8, 32'hDEADBEEF, 32'h12345678, 3'b001, 4'h0, -1, 0);
      send_packet(8, 32'h0F0F0F0F, 32'hA5A5A5A5, 3'b010, 4'h0, -1, 1);
      send_packet(8, 32'h11111111, 32'h22222222, 3'b100, 4'h0, 2, 1);
      send_packet(8, 32'h00000009, 32'h00000004, 3'b101, 4'h0, -1, 0);

      // Reset after four data frames drops the packet silently.
      for (int i = 0; i < 4; i++) send_frame(1'b0, 8'($urandom), 1'b1);
      @(negedge clk);
      sin = 1'b1;
      check(busy == 1'b1, "busy_mid_packet", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check(busy == 1'b0, "busy_after_reset", 64'(busy), 64'd0);
      send_packet(8, 32'hFFFF0000, 32'h00FF00FF, 3'b000, 4'h0, -1, 1);

`ifdef MTM_DESER_TIMEOUT_EN
      for (int i = 0; i < 3; i++) send_frame(1'b0, 8'($urandom), 1'b1);
      push_err(3'b100);
      idle(TIMEOUT_CYCLES + 5);
      check(busy == 1'b0, "busy_after_timeout", 64'(busy), 64'd0);
      send_packet(8, 32'h3, 32'h4, 3'b101, 4'h0, -1, 1);
`endif

      // Randomized packets across all outcome classes.
      for (int n = 0; n < 40; n++) begin
         cat = int'($urandom_range(0, 9));
         case (cat)
            0: send_packet(7, $urandom, $urandom, legal_ops[$urandom_range(0, 3)], 4'h0, -1, 2);
            1: send_packet(9, $urandom, $urandom, legal_ops[$urandom_range(0, 3)], 4'h0, -1, 2);
            2: send_packet(8, $urandom, $urandom, legal_ops[$urandom_range(0, 3)],
                           4'($urandom_range(1, 15)), -1, 2);
            3: send_packet(8, $urandom, $urandom, bad_ops[$urandom_range(0, 3)], 4'h0, -1, 2);
            4: send_packet(8, $urandom, $urandom, legal_ops[$urandom_range(0, 3)], 4'h0,
                           int'($urandom_range(0, 7)), 2);
            default: send_packet(8, $urandom, $urandom, legal_ops[$urandom_range(0, 3)],
                                 4'h0, -1, 2);
         endcase
      end

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      check(exp_q.size() == 0, "drain_pending", 64'(exp_q.size()), 64'd0);
      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
